e15_prog_loader: RTL and testbench
==================================

// Module: e15_prog_loader
// PURPOSE
//  Upstream stage of the E15 processor: replaces its hard-wired program ROM.
//  Accepts a program as a stream of 4-bit nibbles over a valid/ready handshake.
//  Assembles nibbles into 12-bit instructions, writes them to a 16x12 program memory,
//  then releases the processor (cpu_run). Processor fetches via combinational read port.
// PARAMETERS
//  AW      4   program memory address width (DEPTH = 2**AW = 16 words)
//  IW      12  instruction width {opCode[3:0], src[1:0], dst[1:0], immData[3:0]}
//  NW      4   input nibble width (IW/NW = 3 nibbles per instruction)
// PORTS
//  clk           in   1    clock, all state updates on posedge
//  rst           in   1    asynchronous reset, active-high
//  start         in   1    one-cycle pulse: begin (re)loading at address 0
//  in_valid      in   1    in_nibble is valid
//  in_nibble     in   4    program nibble, most-significant nibble of each word first
//  in_last       in   1    qualifies final nibble of the program
//  in_ready      out  1    loader accepts a nibble this cycle
//  fetch_addr    in   4    processor pc
//  fetch_instr   out  12   mem[fetch_addr], combinational
//  cpu_run       out  1    program loaded; processor may execute
//  load_err      out  1    malformed program stream detected
//  words_loaded  out  5    number of complete words written since last start (0..16)
// BEHAVIOUR
//  Reset (async): state=IDLE; all 16 words = 12'h000 (jmp +0, processor spins in place);
//   wptr=0, nib_cnt=0, in_ready=0, cpu_run=0, load_err=0, words_loaded=0.
//  States: IDLE, LOAD, RUN, ERR. Outputs are decoded from registered state:
//   in_ready=(state==LOAD); cpu_run=(state==RUN); load_err=(state==ERR).
//  Accept = in_valid & in_ready. Nibble 0 -> bits[11:8], 1 -> [7:4], 2 -> [3:0].
//  On the accept of nibble 2: mem[wptr] <= {hold[11:4], in_nibble}; wptr++; words_loaded++.
//   Write takes effect at that posedge. No partial words are ever written.
//  Transitions (evaluated at posedge):
//   any state, start=1  -> LOAD; wptr=0, nib_cnt=0, words_loaded=0.
//    start has priority over a same-cycle accept; that nibble is dropped.
//    Memory is not cleared: words beyond the new program keep old contents.
//   LOAD, accept nib 2, in_last=1        -> RUN (cpu_run high the next cycle).
//   LOAD, accept nib 0/1, in_last=1      -> ERR (truncated word).
//   LOAD, accept nib 0 when words_loaded==16 -> ERR (overflow; nothing written).
//   LOAD, accept nib 2 of word 16, in_last=0 -> stay LOAD. Only in_last or start can exit.
//   RUN, ERR: hold until start or rst. IDLE: hold until start.
//  in_valid while in_ready=0 is ignored; no state change.
//  fetch_instr is valid in every state.
//   A same-cycle write to fetch_addr shows the old word until the next cycle.
//  wptr is 4 bits and wraps 15->0 after word 16. words_loaded (5 bits) saturates at 16.
//  Reset mid-LOAD: all loaded words are lost (memory back to 12'h000).
// TESTING
//  1 rst, then idle 5 cycles -> fetch_instr=12'h000 @all addr, cpu_run=0, in_ready=0.
//  2 start; nibbles 9,0,3 (last) -> mem[0]=12'h903 (movi r3,3).
//    Next cycle: cpu_run=1, words_loaded=1, in_ready=0.
//  3 start; 16 words 12'hB01..; last on nibble 48 -> RUN, words_loaded=16, mem[15] correct.
//    Repeat without last, then send a 49th nibble -> load_err=1, mem[0] unchanged.
//  4 start; nibbles A,1 with last on 2nd -> ERR, words_loaded=0, mem[0] keeps prior value.
//    Then start -> in_ready=1, load_err=0.
//  5 in_valid toggled every other cycle; start coincident with a nibble accept.
//    -> the coincident nibble is dropped; words assembled only from accepted nibbles.
//  6 Load a 3-word program; assert rst mid-2nd-word.
//    -> mem all 12'h000, IDLE, outputs at reset values immediately (async).

Source files
------------

// File: rtl/e15_prog_loader.sv
// Nibble-stream program loader for the E15 core; words land in memory on the accept of the third nibble.
// Backpressure: in_ready is high only in LOAD; fetch_instr is a combinational read of the program memory.
module e15_prog_loader #(
  parameter int AW = 4,
  parameter int IW = 12,
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [NW-1:0] in_nibble,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [IW-1:0] fetch_instr,
  output logic          cpu_run,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  localparam int DEPTH = 2 ** AW;
  localparam int NPW   = IW / NW;
  localparam int CW    = $clog2(NPW);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

  state_t          state, stateNext;
  logic [AW-1:0]   wPtr;
  logic [CW-1:0]   nibCnt;
  logic [IW-NW-1:0] hold;
  logic [AW:0]     wordsLoaded;
  logic [IW-1:0]   mem [DEPTH];

  logic accept, doHold, doWrite;

  assign accept = in_valid && (state == LOAD);

  always_comb begin
    stateNext = state;
    doHold    = 1'b0;
    doWrite   = 1'b0;
    if (start) begin
      stateNext = LOAD;
    end else if (accept) begin
      if (nibCnt == CW'(NPW - 1)) begin
        doWrite = 1'b1;
        if (in_last) stateNext = RUN;
      end else if (nibCnt == '0 && wordsLoaded == (AW+1)'(DEPTH)) begin
        // Memory is full: a further word start is an overflow, nothing is written.
        stateNext = ERR;
      end else if (in_last) begin
        stateNext = ERR;
      end else begin
        doHold = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wPtr        <= '0;
      nibCnt      <= '0;
      hold        <= '0;
      wordsLoaded <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= stateNext;
      if (start) begin
        wPtr        <= '0;
        nibCnt      <= '0;
        wordsLoaded <= '0;
      end else if (doHold) begin
        hold   <= {hold[IW-2*NW-1:0], in_nibble};
        nibCnt <= nibCnt + 1'b1;
      end else if (doWrite) begin
        mem[wPtr] <= {hold, in_nibble};
        wPtr      <= wPtr + 1'b1;
        nibCnt    <= '0;
        if (wordsLoaded != (AW+1)'(DEPTH)) wordsLoaded <= wordsLoaded + 1'b1;
      end
    end
  end

  assign in_ready     = (state == LOAD);
  assign cpu_run      = (state == RUN);
  assign load_err     = (state == ERR);
  assign words_loaded = wordsLoaded;
  assign fetch_instr  = mem[fetch_addr];

endmodule

// File: tb/tb_e15_prog_loader.sv
// Directed bench for e15_prog_loader: expected memory words are queued as nibbles are
// driven and compared through the fetch port once each load completes.
module tb_e15_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_nibble = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [3:0]  fetch_addr = '0;
  logic [11:0] fetch_instr;
  logic        cpu_run;
  logic        load_err;
  logic [4:0]  words_loaded;

  typedef struct {
    logic [3:0]  addr;
    logic [11:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  e15_prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_nibble(in_nibble),
    .in_last(in_last), .in_ready(in_ready), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .cpu_run(cpu_run), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] n, input logic last);
    int waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    check("in_ready_wait", {15'd0, in_ready}, 16'd1);
    in_valid  = 1'b1;
    in_nibble = n;
    in_last   = last;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic sendWord(input logic [3:0] a, input logic [11:0] w, input logic last);
    exp_t e;
    send(w[11:8], 1'b0);
    send(w[7:4], 1'b0);
    send(w[3:0], last);
    e.addr = a;
    e.data = w;
    sb.push_back(e);
  endtask

  task automatic pushOld(input logic [3:0] a, input logic [11:0] w);
    exp_t e;
    e.addr = a;
    e.data = w;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      fetch_addr = e.addr;
      #1;
      check(tag, {4'd0, fetch_instr}, {4'd0, e.data});
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 4'(a);
      #1;
      check(tag, {4'd0, fetch_instr}, 16'h0000);
    end
  endtask

  initial begin
    // 1: reset and idle
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkAllZero("reset_mem");
    check("reset_cpu_run", {15'd0, cpu_run}, 16'd0);
    check("reset_in_ready", {15'd0, in_ready}, 16'd0);
    check("reset_load_err", {15'd0, load_err}, 16'd0);
    check("reset_words", {11'd0, words_loaded}, 16'd0);

    // 2: single word program
    doStart();
    check("load_in_ready", {15'd0, in_ready}, 16'd1);
    sendWord(4'd0, 12'h903, 1'b1);
    check("single_cpu_run", {15'd0, cpu_run}, 16'd1);
    check("single_words", {11'd0, words_loaded}, 16'd1);
    check("single_in_ready", {15'd0, in_ready}, 16'd0);
    drain("single_mem");

    // 3a: full 16-word program, last on the 48th nibble
    doStart();
    for (int w = 0; w < 16; w++)
      sendWord(4'(w), 12'hB01 + 12'(w), w == 15);
    check("full_cpu_run", {15'd0, cpu_run}, 16'd1);
    check("full_words", {11'd0, words_loaded}, 16'd16);
    drain("full_mem");

    // 3b: 16 words without last, then a 49th nibble overflows
    doStart();
    for (int w = 0; w < 16; w++)
      sendWord(4'(w), 12'hC00 + 12'(w), 1'b0);
    check("nolast_in_ready", {15'd0, in_ready}, 16'd1);
    check("nolast_words", {11'd0, words_loaded}, 16'd16);
    check("nolast_err", {15'd0, load_err}, 16'd0);
    drain("nolast_mem");
    send(4'hF, 1'b0);
    check("ovf_err", {15'd0, load_err}, 16'd1);
    check("ovf_words", {11'd0, words_loaded}, 16'd16);
    pushOld(4'd0, 12'hC00);
    drain("ovf_mem0");

    // 4: truncated word
    doStart();
    send(4'hA, 1'b0);
    send(4'h1, 1'b1);
    check("trunc_err", {15'd0, load_err}, 16'd1);
    check("trunc_words", {11'd0, words_loaded}, 16'd0);
    pushOld(4'd0, 12'hC00);
    drain("trunc_mem0");
    doStart();
    check("restart_in_ready", {15'd0, in_ready}, 16'd1);
    check("restart_err", {15'd0, load_err}, 16'd0);

    // 5: gapped valid, start coincident with an accept drops that nibble
    send(4'hD, 1'b0);
    start = 1'b1;
    in_valid = 1'b1;
    in_nibble = 4'h7;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    check("coinc_words", {11'd0, words_loaded}, 16'd0);
    in_valid = 1'b0; tick(); send(4'h2, 1'b0);
    in_valid = 1'b0; tick(); send(4'h3, 1'b0);
    in_valid = 1'b0; tick(); send(4'h4, 1'b1);
    pushOld(4'd0, 12'h234);
    pushOld(4'd1, 12'hC01);
    check("gap_cpu_run", {15'd0, cpu_run}, 16'd1);
    check("gap_words", {11'd0, words_loaded}, 16'd1);
    in_valid = 1'b1;
    in_nibble = 4'h5;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    check("ignored_cpu_run", {15'd0, cpu_run}, 16'd1);
    check("ignored_words", {11'd0, words_loaded}, 16'd1);
    drain("gap_mem");

    // 6: reset in the middle of the second word
    doStart();
    sendWord(4'd0, 12'h111, 1'b0);
    send(4'h2, 1'b0);
    send(4'h2, 1'b0);
    sb.delete();
    #2;
    rst = 1'b1;
    #1;
    check("arst_in_ready", {15'd0, in_ready}, 16'd0);
    check("arst_cpu_run", {15'd0, cpu_run}, 16'd0);
    check("arst_err", {15'd0, load_err}, 16'd0);
    check("arst_words", {11'd0, words_loaded}, 16'd0);
    checkAllZero("arst_mem");
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", {15'd0, in_ready}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
